axis_packet_source: RTL and testbench

- AXI-Stream master (transmitter) that generates framed packets of incrementing data on command.
- Drives the input side of stream blocks such as the skid buffer, for bring-up, loopback and formal harnesses.
- Fully honours backpressure and AXI-Stream stability rules, so an axi_stream_slave_monitor attached to its output port passes.

---
 rtl/axis_packet_source.sv | 172 +++++++++++++++++
 tb/tb_axis_packet_source.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_source.sv
// axis_packet_source
//
// AXI-Stream master that emits one framed packet of incrementing data per
// accepted command. The first beat carries cmd_seed, each following beat is
// the previous value plus one (modulo 2^DATA_WIDTH), and tlast marks beat
// cmd_len+1. Backpressure is honoured: tvalid is held until the handshake and
// tdata/tlast are stable while stalled.
//
// Optional feature: define AXIS_PACKET_SOURCE_GAP_EN to insert GAP_CYCLES
// idle cycles (tvalid=0, cmd_ready=0, busy=1) after every packet.
//
// Parameters:
//   DATA_WIDTH  tdata width in bits (multiple of 8)
//   LEN_WIDTH   width of cmd_len; largest packet is 2^LEN_WIDTH beats
//   GAP_CYCLES  idle cycles after each packet when the gap feature is on (>=1)
//
// Ports:
//   aclk       clock, rising edge
//   aresetn    asynchronous active-low reset
//   cmd_valid  command request
//   cmd_ready  command accepted when cmd_valid && cmd_ready (registered)
//   cmd_len    beats in packet minus one
//   cmd_seed   tdata of the first beat
//   tvalid     stream valid
//   tready     stream ready
//   tdata      stream data
//   tkeep      all ones
//   tstrb      all ones
//   tlast      final beat of a packet
//   busy       high whenever the source is not idle
//   pkt_count  completed packets, wraps modulo 2^16
module axis_packet_source #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_WIDTH-1:0]    cmd_len,
  input  logic [DATA_WIDTH-1:0]   cmd_seed,
  output logic                    tvalid,
  input  logic                    tready,
  output logic [DATA_WIDTH-1:0]   tdata,
  output logic [DATA_WIDTH/8-1:0] tkeep,
  output logic [DATA_WIDTH/8-1:0] tstrb,
  output logic                    tlast,
  output logic                    busy,
  output logic [15:0]             pkt_count
);

  if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
    $error("DATA_WIDTH must be a multiple of 8");
  end
  if (GAP_CYCLES < 1) begin : g_bad_gap_cycles
    $error("GAP_CYCLES must be at least 1");
  end

`ifdef AXIS_PACKET_SOURCE_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  state_t                  state;
  state_t                  state_d;
  logic                    cmd_ready_d;
  logic                    accept;
  logic                    beat;
  logic                    last_beat;

  logic                    vld_p0;
  logic                    last_p0;
  logic [DATA_WIDTH-1:0]   data_p0;
  logic [LEN_WIDTH-1:0]    cnt_p0;
  logic [15:0]             pkt_p0;
  logic                    rdy_p0;

  assign accept    = cmd_valid && rdy_p0;
  assign beat      = vld_p0 && tready;
  assign last_beat = beat && last_p0;

`ifdef AXIS_PACKET_SOURCE_GAP_EN
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [GAP_W-1:0] gap_cnt;

  // Counts down the remaining idle cycles; GAP exits once it reaches zero.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gap_cnt <= '0;
    end else if (last_beat) begin
      gap_cnt <= GAP_W'(GAP_CYCLES - 1);
    end else if (state == GAP && gap_cnt != '0) begin
      gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= IDLE;
      rdy_p0 <= 1'b0;
    end else begin
      state  <= state_d;
      rdy_p0 <= cmd_ready_d;
    end
  end

  always_comb begin
    state_d     = state;
    cmd_ready_d = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_d = SEND;
      end
      SEND: begin
`ifdef AXIS_PACKET_SOURCE_GAP_EN
        if (last_beat) state_d = GAP;
`else
        if (last_beat) state_d = IDLE;
`endif
      end
`ifdef AXIS_PACKET_SOURCE_GAP_EN
      GAP: begin
        if (gap_cnt == '0) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
    // cmd_ready is registered, so it follows the state being entered.
    cmd_ready_d = (state_d == IDLE);
  end

  // Stage p0: beat register driving the stream outputs
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_p0  <= 1'b0;
      last_p0 <= 1'b0;
      data_p0 <= '0;
      cnt_p0  <= '0;
      pkt_p0  <= '0;
    end else if (accept) begin
      vld_p0  <= 1'b1;
      last_p0 <= (cmd_len == '0);
      data_p0 <= cmd_seed;
      cnt_p0  <= cmd_len;
    end else if (beat) begin
      if (last_p0) begin
        vld_p0  <= 1'b0;
        last_p0 <= 1'b0;
        pkt_p0  <= pkt_p0 + 16'd1;
      end else begin
        data_p0 <= data_p0 + DATA_WIDTH'(1);
        cnt_p0  <= cnt_p0 - LEN_WIDTH'(1);
        // cnt_p0 holds beats remaining after the current one.
        last_p0 <= (cnt_p0 == LEN_WIDTH'(1));
      end
    end
  end

  assign cmd_ready = rdy_p0;
  assign tvalid    = vld_p0;
  assign tlast     = last_p0;
  assign tdata     = data_p0;
  assign tkeep     = '1;
  assign tstrb     = '1;
  assign busy      = (state != IDLE);
  assign pkt_count = pkt_p0;

endmodule

// File: tb/tb_axis_packet_source.sv
module tb_axis_packet_source;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GC = 2;
`ifdef AXIS_PACKET_SOURCE_GAP_EN
  localparam int GAP = GC;
`else
  localparam int GAP = 0;
`endif

  logic          aclk = 1'b0;
  logic          aresetn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [LW-1:0] cmd_len = '0;
  logic [DW-1:0] cmd_seed = '0;
  logic          tvalid;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic [DW/8-1:0] tkeep;
  logic [DW/8-1:0] tstrb;
  logic          tlast;
  logic          busy;
  logic [15:0]   pkt_count;

  axis_packet_source #(
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW),
    .GAP_CYCLES(GC)
  ) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_len  (cmd_len),
    .cmd_seed (cmd_seed),
    .tvalid   (tvalid),
    .tready   (tready),
    .tdata    (tdata),
    .tkeep    (tkeep),
    .tstrb    (tstrb),
    .tlast    (tlast),
    .busy     (busy),
    .pkt_count(pkt_count)
  );

  always #5 aclk = ~aclk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge aclk) cyc <= cyc + 1;

  // Model: the beats still owed to the stream, plus handshake-level state.
  logic [DW-1:0] exp_d[$];
  bit            exp_l[$];
  bit            exp_rdy = 1'b0;
  bit            exp_busy = 1'b0;
  logic [15:0]   exp_pkt = '0;
  int            gap_left = 0;
  bit            popped_last;
  logic [DW-1:0] popped_data;

  // Observation log of accepted beats and timing markers.
  logic [DW-1:0] obs_d[$];
  bit            obs_l[$];
  int            hs_cnt = 0;
  int            hs_cyc = 0;
  int            vld_cyc = 0;
  int            low_run = 0;
  int            gap_seen = -1;
  bit            prev_vld = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  always @(negedge aclk) begin
    if (!aresetn) begin
      chk("rst_tvalid", 32'(tvalid), 32'(0));
      chk("rst_tlast", 32'(tlast), 32'(0));
      chk("rst_tdata", 32'(tdata), 32'(0));
      chk("rst_cmd_ready", 32'(cmd_ready), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_pkt_count", 32'(pkt_count), 32'(0));
      exp_d.delete();
      exp_l.delete();
      exp_rdy  = 1'b0;
      exp_busy = 1'b0;
      exp_pkt  = '0;
      gap_left = 0;
      prev_vld = 1'b0;
    end else begin
      chk("tvalid", 32'(tvalid), 32'(exp_d.size() != 0));
      if (exp_d.size() != 0) begin
        chk("tdata", 32'(tdata), 32'(exp_d[0]));
        chk("tlast", 32'(tlast), 32'(exp_l[0]));
      end else begin
        chk("tlast_idle", 32'(tlast), 32'(0));
      end
      chk("cmd_ready", 32'(cmd_ready), 32'(exp_rdy));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("pkt_count", 32'(pkt_count), 32'(exp_pkt));
      chk("tkeep_tstrb", 32'({tkeep, tstrb}), 32'(2'b11));

      if (tvalid && !prev_vld) begin
        vld_cyc  = cyc;
        gap_seen = low_run;
      end
      if (!tvalid) low_run++;
      prev_vld = tvalid;
      if (cmd_valid && cmd_ready) begin
        hs_cnt++;
        hs_cyc = cyc;
      end
      if (tvalid && tready) begin
        obs_d.push_back(tdata);
        obs_l.push_back(tlast);
        if (tlast) low_run = 0;
      end

      // What the source must do at the coming clock edge.
      if (exp_rdy && cmd_valid) begin
        for (int i = 0; i <= int'(cmd_len); i++) begin
          exp_d.push_back(cmd_seed + DW'(i));
          exp_l.push_back(i == int'(cmd_len));
        end
        exp_rdy  = 1'b0;
        exp_busy = 1'b1;
      end else if (exp_d.size() != 0 && tready) begin
        popped_data = exp_d.pop_front();
        popped_last = exp_l.pop_front();
        if (popped_last) begin
          exp_pkt = exp_pkt + 16'd1;
          if (GAP > 0) begin
            gap_left = GAP;
          end else begin
            exp_busy = 1'b0;
            exp_rdy  = 1'b1;
          end
        end
      end else if (gap_left > 0) begin
        gap_left--;
        if (gap_left == 0) begin
          exp_busy = 1'b0;
          exp_rdy  = 1'b1;
        end
      end else if (!exp_busy) begin
        exp_rdy = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic issue_cmd(input int len, input int seed, input bit [15:0] pat, input int patn);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    cmd_len   = LW'(len);
    cmd_seed  = DW'(seed);
    cmd_valid = 1'b1;
    while (!acc && n < 50) begin
      @(negedge aclk);
      acc = cmd_ready;
      step();
      n++;
    end
    chk("cmd_accept", 32'(acc), 32'(1));
    cmd_valid = 1'b0;
    tready = (patn > 0) ? pat[0] : 1'b1;
  endtask

  task automatic run_packet(input int len, input int seed, input bit [15:0] pat, input int patn);
    int start;
    int k;
    start = obs_d.size();
    issue_cmd(len, seed, pat, patn);
    k = 1;
    while (obs_d.size() - start < len + 1 && k < 2000) begin
      step();
      tready = (k < patn) ? pat[k] : 1'b1;
      k++;
    end
    chk("pkt_done", 32'(obs_d.size() - start), 32'(len + 1));
  endtask

  logic [7:0] t1_tab [4] = '{8'h10, 8'h11, 8'h12, 8'h13};
  logic [7:0] t3_tab [3] = '{8'hFE, 8'hFF, 8'h00};
  logic [7:0] t6_tab [4] = '{8'h60, 8'h61, 8'h60, 8'h61};

  initial begin
    int s;
    int bad;
    int lasts;
    int h0;
    int n;

    aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(cmd_ready), 32'(0));
    step();
    chk("rdy_after_edge", 32'(cmd_ready), 32'(1));

    // 4-beat packet at full throughput
    s = obs_d.size();
    run_packet(3, 'h10, 16'h0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("t1_data", 32'(obs_d[s+i]), 32'(t1_tab[i]));
      chk("t1_last", 32'(obs_l[s+i]), 32'(i == 3));
    end
    chk("t1_latency", 32'(vld_cyc - hs_cyc), 32'(1));
    chk("t1_pkt_count", 32'(pkt_count), 32'(1));

    // single-beat packet
    step();
    s = obs_d.size();
    run_packet(0, 'hFF, 16'h0, 0);
    chk("t2_data", 32'(obs_d[s]), 32'(8'hFF));
    chk("t2_last", 32'(obs_l[s]), 32'(1));
    chk("t2_busy_after", 32'(busy), 32'(GAP > 0));

    // stalls with data wrap: tready 1,0,0,1,0,1
    step();
    s = obs_d.size();
    run_packet(2, 'hFE, 16'h0029, 6);
    for (int i = 0; i < 3; i++) begin
      chk("t3_data", 32'(obs_d[s+i]), 32'(t3_tab[i]));
      chk("t3_last", 32'(obs_l[s+i]), 32'(i == 2));
    end

    // maximum length packet
    step();
    s = obs_d.size();
    run_packet(255, 0, 16'h0, 0);
    bad = 0;
    lasts = 0;
    for (int i = 0; i < 256 && s + i < obs_d.size(); i++) begin
      if (obs_d[s+i] != 8'(i)) bad++;
      if (obs_l[s+i]) lasts++;
    end
    chk("t4_ramp_bad", 32'(bad), 32'(0));
    chk("t4_last_count", 32'(lasts), 32'(1));
    chk("t4_final_last", 32'(obs_l[obs_l.size()-1]), 32'(1));
    chk("t4_pkt_count", 32'(pkt_count), 32'(4));

    // reset during beat 2 of a 5-beat packet
    step();
    issue_cmd(4, 'h20, 16'h0, 0);
    step();
    #2;
    aresetn = 1'b0;
    #1;
    chk("t5_tvalid_async", 32'(tvalid), 32'(0));
    chk("t5_tlast_async", 32'(tlast), 32'(0));
    chk("t5_pkt_cleared", 32'(pkt_count), 32'(0));
    step();
    step();
    aresetn = 1'b1;
    step();
    s = obs_d.size();
    run_packet(2, 'h40, 16'h0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("t5_data", 32'(obs_d[s+i]), 32'(8'h40 + i));
    end
    chk("t5_pkt_count", 32'(pkt_count), 32'(1));

    // two queued commands, cmd_valid held high
    step();
    s = obs_d.size();
    h0 = hs_cnt;
    cmd_len   = LW'(1);
    cmd_seed  = DW'('h60);
    tready    = 1'b1;
    cmd_valid = 1'b1;
    n = 0;
    while (hs_cnt < h0 + 2 && n < 100) begin
      step();
      n++;
    end
    cmd_valid = 1'b0;
    chk("t6_two_cmds", 32'(hs_cnt - h0), 32'(2));
    n = 0;
    while (obs_d.size() - s < 4 && n < 100) begin
      step();
      n++;
    end
    chk("t6_beats", 32'(obs_d.size() - s), 32'(4));
    for (int i = 0; i < 4 && s + i < obs_d.size(); i++) begin
      chk("t6_data", 32'(obs_d[s+i]), 32'(t6_tab[i]));
    end
    chk("t6_idle_gap", 32'(gap_seen), 32'(1 + GAP));

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
